// File: rtl/adc366x_tx_emu.sv
// ADC366x-style LVDS transmitter emulator: sample FIFO, pattern sources, 4 data lanes plus frame lane
// as 8-bit words for external 8:1 serialisers. Optional PRBS-15 source enabled by ADC366X_TX_PRBS_EN.
//
// state   | meaning
// ST_OFF  | disabled or first enabled edge; pipeline empty
// ST_ARM  | stage 1 sampling, ser_dat_o still idle (zero)
// ST_RUN  | both stages active, frame lane running
module adc366x_tx_emu #(
    parameter int FD = 4,
    parameter int UW = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [31:0]           cfg_pat_i,
    input  logic [2:0]            cfg_slip_i,
    input  logic [4:0]            cfg_inv_i,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [39:0]           ser_dat_o,
    output logic [$clog2(FD):0]   sts_lvl_o,
    output logic [UW-1:0]         sts_unf_o
);

    localparam int AW = $clog2(FD);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {ST_OFF, ST_ARM, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic            act1, act2;
    logic            alive;
    logic [31:0]     mem [FD];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   lvl;
    logic            full, empty, push, pop, stream_sel;
    logic [31:0]     smp;
    logic [15:0]     ramp;
    logic [UW-1:0]   unf;
    logic [15:0]     lane_a, lane_b;
    logic [4:0][7:0] cur, prev, word;
    logic            phase;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ST_OFF;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        act1      = 1'b0;
        act2      = 1'b0;
        if (!cfg_en_i) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:  state_nxt = ST_ARM;
                ST_ARM: begin
                    act1      = 1'b1;
                    state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    act1 = 1'b1;
                    act2 = 1'b1;
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // Keeps s_ready_o low while reset is asserted and for the first edge after release.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) alive <= 1'b0;
        else         alive <= 1'b1;
    end

`ifdef ADC366X_TX_PRBS_EN
    assign stream_sel = (cfg_mode_i == 2'd0);
`else
    assign stream_sel = (cfg_mode_i == 2'd0) || (cfg_mode_i == 2'd3);
`endif

    assign full      = (lvl == LW'(FD));
    assign empty     = (lvl == '0);
    assign s_ready_o = cfg_en_i && alive && !full;
    assign push      = s_valid_i && s_ready_o;
    assign pop       = act1 && stream_sel && !empty;
    assign sts_lvl_o = lvl;
    assign sts_unf_o = unf;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= s_dat_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else if (!cfg_en_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            lvl <= lvl + LW'(push) - LW'(pop);
        end
    end

`ifdef ADC366X_TX_PRBS_EN
    logic [14:0] lfsr;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                              lfsr <= 15'h7FFF;
        else if (!cfg_en_i)                       lfsr <= 15'h7FFF;
        else if (act1 && cfg_mode_i == 2'd3)      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            smp  <= '0;
            ramp <= '0;
            unf  <= '0;
        end else if (!cfg_en_i) begin
            smp  <= '0;
            ramp <= '0;
            unf  <= '0;
        end else if (act1) begin
            if (stream_sel) begin
                if (!empty)          smp <= mem[rd_ptr];
                else if (unf != '1)  unf <= unf + UW'(1);
            end else if (cfg_mode_i == 2'd1) begin
                smp  <= {~ramp, ramp};
                ramp <= ramp + 16'd1;
            end else if (cfg_mode_i == 2'd2) begin
                smp <= cfg_pat_i;
            end
`ifdef ADC366X_TX_PRBS_EN
            else begin
                smp <= {~{1'b0, lfsr}, {1'b0, lfsr}};
            end
`endif
        end
    end

    // Even sample bits go to the low lane, odd bits to the high lane, LSB pair sent first.
    function automatic logic [15:0] lane_map(input logic [15:0] d);
        logic [15:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k]     = d[14-2*k];
            r[8+k]   = d[15-2*k];
        end
        return r;
    endfunction

    assign lane_a = lane_map(smp[15:0]);
    assign lane_b = lane_map(smp[31:16]);

    always_comb begin
        cur[0] = phase ? 8'h00 : 8'hFF;
        cur[1] = lane_b[7:0];
        cur[2] = lane_b[15:8];
        cur[3] = lane_a[7:0];
        cur[4] = lane_a[15:8];
        for (int l = 0; l < 5; l++) begin
            word[l] = 8'({prev[l], cur[l]} >> cfg_slip_i) ^ {8{cfg_inv_i[l]}};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ser_dat_o <= '0;
            prev      <= '0;
            phase     <= 1'b0;
        end else if (!cfg_en_i) begin
            ser_dat_o <= '0;
            prev      <= '0;
            phase     <= 1'b0;
        end else if (act2) begin
            ser_dat_o <= word;
            prev      <= cur;
            phase     <= ~phase;
        end else begin
            ser_dat_o <= '0;
        end
    end

endmodule

// File: tb/tb_adc366x_tx_emu.sv
// Randomised bench for adc366x_tx_emu against a bit-stream reference model (default build, no PRBS).
module tb_adc366x_tx_emu;

    localparam int FD = 4;
    localparam int UW = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cfg_en_i;
    logic [1:0]  cfg_mode_i;
    logic [31:0] cfg_pat_i;
    logic [2:0]  cfg_slip_i;
    logic [4:0]  cfg_inv_i;
    logic [31:0] s_dat_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [39:0] ser_dat_o;
    logic [2:0]  sts_lvl_o;
    logic [UW-1:0] sts_unf_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    adc366x_tx_emu #(.FD(FD), .UW(UW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_mode_i(cfg_mode_i),
        .cfg_pat_i(cfg_pat_i), .cfg_slip_i(cfg_slip_i), .cfg_inv_i(cfg_inv_i),
        .s_dat_i(s_dat_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .ser_dat_o(ser_dat_o), .sts_lvl_o(sts_lvl_o), .sts_unf_o(sts_unf_o)
    );

    always #5 clk_i = ~clk_i;

    // reference model: FIFO as a queue, lanes as serial bit histories
    logic [31:0] m_fifo [$];
    bit          m_hist [5][$];
    bit          m_alive;
    int          m_on;
    logic [31:0] m_smp;
    int          m_unf;
    logic [15:0] m_ramp;
    bit          m_ph;
    logic [39:0] m_ser;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_flush();
        m_fifo.delete();
        m_on   = 0;
        m_smp  = '0;
        m_unf  = 0;
        m_ramp = '0;
        m_ph   = 1'b0;
        m_ser  = '0;
        for (int l = 0; l < 5; l++) begin
            m_hist[l].delete();
            for (int i = 0; i < 16; i++) m_hist[l].push_back(1'b0);
        end
    endtask

    task automatic model_reset();
        model_flush();
        m_alive = 1'b0;
    endtask

    task automatic model_edge();
        int n, s;
        bit push;
        logic [7:0] w;
        if (!cfg_en_i) begin
            model_flush();
            m_alive = 1'b1;
            return;
        end
        n    = m_fifo.size();
        push = s_valid_i && m_alive && (n < FD);
        s    = int'(cfg_slip_i);
        if (m_on >= 2) begin
            // transmit order: frame bit, then sample bit pairs from the LSB upward
            for (int t = 0; t < 8; t++) begin
                m_hist[0].push_back(!m_ph);
                m_hist[1].push_back(m_smp[16+2*t]);
                m_hist[2].push_back(m_smp[17+2*t]);
                m_hist[3].push_back(m_smp[2*t]);
                m_hist[4].push_back(m_smp[2*t+1]);
            end
            for (int l = 0; l < 5; l++) begin
                while (m_hist[l].size() > 16) void'(m_hist[l].pop_front());
                for (int j = 0; j < 8; j++) w[7-j] = m_hist[l][8-s+j];
                if (cfg_inv_i[l]) w = ~w;
                m_ser[8*l+:8] = w;
            end
            m_ph = !m_ph;
        end else begin
            m_ser = '0;
        end
        if (m_on >= 1) begin
            case (cfg_mode_i)
                2'd1: begin
                    m_smp  = {~m_ramp, m_ramp};
                    m_ramp = m_ramp + 16'd1;
                end
                2'd2: m_smp = cfg_pat_i;
                default: begin
                    if (n > 0)                     m_smp = m_fifo.pop_front();
                    else if (m_unf < (1 << UW) - 1) m_unf++;
                end
            endcase
        end
        if (push) m_fifo.push_back(s_dat_i);
        if (m_on < 2) m_on++;
        m_alive = 1'b1;
    endtask

    task automatic step();
        @(negedge clk_i);
        chk("ready", s_ready_o, cfg_en_i && m_alive && (m_fifo.size() < FD));
        model_edge();
        @(posedge clk_i);
        #1;
        chk("ser", ser_dat_o, m_ser);
        chk("lvl", sts_lvl_o, m_fifo.size());
        chk("unf", sts_unf_o, m_unf);
    endtask

    task automatic async_rst();
        #2;
        rstn_i = 1'b0;
        #1;
        chk("rst_ser", ser_dat_o, 40'h0);
        chk("rst_rdy", s_ready_o, 1'b0);
        chk("rst_lvl", sts_lvl_o, 3'h0);
        chk("rst_unf", sts_unf_o, 4'h0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    initial begin
        rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_mode_i = 2'd0; cfg_pat_i = '0;
        cfg_slip_i = '0; cfg_inv_i = '0; s_dat_i = '0; s_valid_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ser", ser_dat_o, 40'h0);
        chk("rst_rdy", s_ready_o, 1'b0);
        chk("rst_lvl", sts_lvl_o, 3'h0);
        chk("rst_unf", sts_unf_o, 4'h0);
        rstn_i = 1'b1;

        // lane mapping with constant patterns
        cfg_en_i = 1'b1; cfg_mode_i = 2'd2; cfg_pat_i = 32'h0000_0001;
        repeat (6) step();
        chk("a1_l1", ser_dat_o[15:8], 8'h00);
        chk("a1_l2", ser_dat_o[23:16], 8'h00);
        chk("a1_l3", ser_dat_o[31:24], 8'h80);
        chk("a1_l4", ser_dat_o[39:32], 8'h00);
        cfg_pat_i = 32'h8000_8000;
        repeat (3) step();
        chk("msb_l2", ser_dat_o[23:16], 8'h01);
        chk("msb_l4", ser_dat_o[39:32], 8'h01);

        // slip 3: ones then zeros give one mixed word
        cfg_pat_i = 32'hFFFF_FFFF; cfg_slip_i = 3'd3;
        repeat (3) step();
        cfg_pat_i = 32'h0;
        step();
        step();
        chk("slip_l3", ser_dat_o[31:24], 8'hE0);
        chk("slip_l4", ser_dat_o[39:32], 8'hE0);
        step();
        chk("slip_z3", ser_dat_o[31:24], 8'h00);
        cfg_slip_i = 3'd0;

        // consumer stalled in mode 2: FIFO fills without overwrite
        s_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_dat_i = $urandom();
            step();
        end
        chk("full_lvl", sts_lvl_o, 3'd4);
        chk("full_rdy", s_ready_o, 1'b0);
        s_valid_i = 1'b0; cfg_mode_i = 2'd0;
        repeat (4) step();

        // underflow counting and saturation, cleared by disable
        cfg_en_i = 1'b0;
        step();
        cfg_en_i = 1'b1;
        repeat (11) step();
        chk("unf10", sts_unf_o, 4'd10);
        repeat (8) step();
        cfg_en_i = 1'b0;
        step();
        chk("unf_clr", sts_unf_o, 4'd0);

        // inversion of an idle stream after enable
        cfg_inv_i = 5'h1F; cfg_en_i = 1'b1;
        repeat (3) step();
        chk("inv_frm0", ser_dat_o[7:0], 8'h00);
        chk("inv_dat", ser_dat_o[39:8], 32'hFFFF_FFFF);
        step();
        chk("inv_frm1", ser_dat_o[7:0], 8'hFF);
        cfg_inv_i = 5'h00;

        for (int c = 0; c < 1500; c++) begin
            s_valid_i = ($urandom_range(3) != 0);
            s_dat_i   = $urandom();
            if ($urandom_range(39) == 0)
                cfg_mode_i = ($urandom_range(1) != 0) ? 2'd0 : 2'($urandom_range(3));
            if ($urandom_range(29) == 0) cfg_slip_i = 3'($urandom_range(7));
            if ($urandom_range(49) == 0) cfg_inv_i = 5'($urandom());
            if ($urandom_range(29) == 0) cfg_pat_i = $urandom();
            cfg_en_i = ($urandom_range(59) != 0);
            if (c == 700 || c == 1200) async_rst();
            step();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
